lock_ctrl_fsm: RTL and testbench

Sequencing controller for the 4-digit password lock. It collects keypad digits, compares an entered code against the stored password digits, and controls unlock, lockout and inactivity timeouts. It also drives the password-storage block's set/enable/data write interface for password changes. It sits between the keypad debouncer/encoder and the password storage block.

---
 rtl/lock_ctrl_fsm_pkg.sv | 16 +
 rtl/lock_ctrl_fsm_timer.sv | 23 ++
 rtl/lock_ctrl_fsm.sv | 143 ++++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_ctrl_fsm_pkg.sv
// lock_ctrl_fsm_pkg: state encoding, keypad constants and helpers shared by the lock controller
package lock_ctrl_fsm_pkg;
    typedef logic [3:0] digit_t;
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ENTRY       = 3'd1;
    localparam logic [2:0] S_CHECK       = 3'd2;
    localparam logic [2:0] S_UNLOCK      = 3'd3;
    localparam logic [2:0] S_SET_COLLECT = 3'd4;
    localparam logic [2:0] S_SET_WRITE   = 3'd5;
    localparam logic [2:0] S_LOCKOUT     = 3'd6;
    localparam digit_t KEY_CLEAR_MIN = 4'd10;
    localparam int NUM_DIGITS = 4;
    function automatic logic is_clear(input digit_t k);
        return k >= KEY_CLEAR_MIN;
    endfunction
endpackage

// File: rtl/lock_ctrl_fsm_timer.sv
// lock_timer: loadable down-counter that parks at zero and flags expiry
module lock_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;
    // reload on request, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/lock_ctrl_fsm.sv
// lock_ctrl_fsm: keypad code entry, compare, unlock/lockout timing and password-change write sequencing
module lock_ctrl_fsm
    import lock_ctrl_fsm_pkg::*;
#(
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       set_req,
    input  logic       lock_req,
    input  logic [3:0] pwd0,
    input  logic [3:0] pwd1,
    input  logic [3:0] pwd2,
    input  logic [3:0] pwd3,
    output logic       pwd_clr,
    output logic       pwd_set,
    output logic       pwd_wr_en,
    output logic [3:0] pwd_wr_data,
    output logic       unlocked,
    output logic       locked_out,
    output logic       busy,
    output logic       err_pulse,
    output logic       set_done,
    output logic [3:0] fail_cnt
);
    localparam int LU   = LOCKOUT_CYCLES > UNLOCK_CYCLES ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int MAXC = LU > TIMEOUT_CYCLES ? LU : TIMEOUT_CYCLES;
    localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;

    logic [2:0]    state_q, state_d;
    digit_t        entry [NUM_DIGITS];
    digit_t        nw    [NUM_DIGITS];
    logic [2:0]    digit_cnt;
    logic          kd, kc, match, last_digit;
    logic [3:0]    fail_inc;
    logic          tm_load, tm_exp;
    logic [TW-1:0] tm_val;

    assign kd         = key_valid && !is_clear(key_value);
    assign kc         = key_valid && is_clear(key_value);
    assign last_digit = digit_cnt == 3'(NUM_DIGITS - 1);
    assign match      = entry[0] == pwd0 && entry[1] == pwd1 && entry[2] == pwd2 && entry[3] == pwd3;
    assign fail_inc   = fail_cnt >= 4'(MAX_FAIL) ? fail_cnt : fail_cnt + 4'd1;

    // next-state selection; keypad priority inside each state follows digit > CLEAR > timer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        state_d = kd ? S_ENTRY : S_IDLE;
            S_ENTRY:       state_d = (kd && last_digit) ? S_CHECK : (kc || (!kd && tm_exp)) ? S_IDLE : S_ENTRY;
            S_CHECK:       state_d = match ? S_UNLOCK : (fail_inc == 4'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
            S_UNLOCK:      state_d = set_req ? S_SET_COLLECT : (lock_req || kc || tm_exp) ? S_IDLE : S_UNLOCK;
            S_SET_COLLECT: state_d = (kd && last_digit) ? S_SET_WRITE : (kc || (!kd && tm_exp)) ? S_UNLOCK : S_SET_COLLECT;
            S_SET_WRITE:   state_d = digit_cnt == 3'(NUM_DIGITS) ? S_IDLE : S_SET_WRITE;
            S_LOCKOUT:     state_d = tm_exp ? S_IDLE : S_LOCKOUT;
            default:       state_d = S_IDLE;
        endcase
    end

    // one shared timer: restarted on every state change and on each accepted digit
    assign tm_load = (state_d != state_q) || (kd && (state_q == S_ENTRY || state_q == S_SET_COLLECT));
    assign tm_val  = state_d == S_UNLOCK  ? TW'(UNLOCK_CYCLES - 1) :
                     state_d == S_LOCKOUT ? TW'(LOCKOUT_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tm_load),
        .load_val (tm_val),
        .en       (1'b1),
        .expired  (tm_exp)
    );

    // state register plus digit capture, failure counting and result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            entry     <= '{default: '0};
            nw        <= '{default: '0};
            digit_cnt <= '0;
            fail_cnt  <= '0;
            err_pulse <= 1'b0;
            set_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_pulse <= 1'b0;
            set_done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (kd) begin
                        entry[0]  <= key_value;
                        digit_cnt <= 3'd1;
                    end
                end
                S_ENTRY: begin
                    if (kd) begin
                        entry[digit_cnt[1:0]] <= key_value;
                        digit_cnt             <= digit_cnt + 3'd1;
                    end else if (!kc && tm_exp) begin
                        err_pulse <= 1'b1;
                    end
                end
                S_CHECK: begin
                    fail_cnt  <= match ? 4'd0 : fail_inc;
                    err_pulse <= !match;
                end
                S_UNLOCK: digit_cnt <= '0;
                S_SET_COLLECT: begin
                    if (kd) begin
                        nw[digit_cnt[1:0]] <= key_value;
                        digit_cnt          <= last_digit ? 3'd0 : digit_cnt + 3'd1;
                    end else if (kc || tm_exp) begin
                        nw        <= '{default: '0};
                        err_pulse <= !kc;
                    end
                end
                S_SET_WRITE: begin
                    digit_cnt <= digit_cnt + 3'd1;
                    set_done  <= digit_cnt == 3'(NUM_DIGITS);
                end
                S_LOCKOUT: begin
                    if (tm_exp)
                        fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // SET_WRITE: step 0 re-initialises storage, steps 1..4 write the shadow digits in order
    assign pwd_set     = state_q == S_SET_WRITE;
    assign pwd_clr     = pwd_set && digit_cnt == 3'd0;
    assign pwd_wr_en   = pwd_set && digit_cnt != 3'd0 && digit_cnt <= 3'(NUM_DIGITS);
    assign pwd_wr_data = pwd_wr_en ? nw[2'(digit_cnt - 3'd1)] : 4'd0;
    assign unlocked    = state_q == S_UNLOCK || state_q == S_SET_COLLECT || state_q == S_SET_WRITE;
    assign locked_out  = state_q == S_LOCKOUT;
    assign busy        = state_q == S_CHECK || state_q == S_SET_WRITE || state_q == S_LOCKOUT;
endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb_lock_ctrl_fsm: directed scenarios checked against a time-stamped behavioural model every cycle
module tb_lock_ctrl_fsm;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_T   = 1000;
    localparam int OPEN_T   = 500;
    localparam int IDLE_T   = 2000;

    logic       clk = 0;
    logic       rst;
    logic       key_valid, set_req, lock_req;
    logic [3:0] key_value;
    logic [3:0] pwd0, pwd1, pwd2, pwd3;
    logic       pwd_clr, pwd_set, pwd_wr_en, unlocked, locked_out, busy, err_pulse, set_done;
    logic [3:0] pwd_wr_data, fail_cnt;

    int n_chk = 0;
    int n_fail = 0;

    lock_ctrl_fsm dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_value(key_value),
        .set_req(set_req), .lock_req(lock_req),
        .pwd0(pwd0), .pwd1(pwd1), .pwd2(pwd2), .pwd3(pwd3),
        .pwd_clr(pwd_clr), .pwd_set(pwd_set), .pwd_wr_en(pwd_wr_en), .pwd_wr_data(pwd_wr_data),
        .unlocked(unlocked), .locked_out(locked_out), .busy(busy),
        .err_pulse(err_pulse), .set_done(set_done), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // password storage stand-in: reset to 0000, indexed writes driven by the controller
    logic [3:0] stored [4];
    logic [1:0] widx;
    int         n_writes = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stored <= '{default: 4'd0};
            widx   <= 2'd0;
        end else begin
            if (pwd_clr) widx <= 2'd0;
            if (pwd_wr_en) begin
                stored[widx] <= pwd_wr_data;
                widx         <= widx + 2'd1;
                n_writes     <= n_writes + 1;
            end
        end
    end
    assign pwd0 = stored[0];
    assign pwd1 = stored[1];
    assign pwd2 = stored[2];
    assign pwd3 = stored[3];

    // behavioural model: a mode, the cycle it was entered, and digit queues
    typedef enum int {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_NEW, M_WRITE, M_LOCK} mode_t;
    mode_t mode;
    int    code[$];
    int    newc[$];
    int    mcode[4];
    int    fails, cyc, since, spent, ph;
    bit    e_err, e_done, dig, clr, ok;

    function automatic void go(input mode_t m);
        mode  = m;
        since = cyc + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode = M_IDLE; code.delete(); newc.delete(); mcode = '{0, 0, 0, 0};
            fails = 0; cyc = 0; since = 0; e_err = 0; e_done = 0;
        end else begin
            dig = key_valid && key_value < 10;
            clr = key_valid && key_value >= 10;
            spent = cyc - since + 1;
            e_err = 0;
            e_done = 0;
            case (mode)
                M_IDLE: if (dig) begin code.delete(); code.push_back(int'(key_value)); go(M_ENTRY); end
                M_ENTRY: begin
                    if (dig) begin
                        code.push_back(int'(key_value));
                        if (code.size() == 4) go(M_CHECK); else since = cyc + 1;
                    end else if (clr) go(M_IDLE);
                    else if (spent == IDLE_T) begin e_err = 1; go(M_IDLE); end
                end
                M_CHECK: begin
                    ok = 1;
                    for (int i = 0; i < 4; i++) if (code[i] != mcode[i]) ok = 0;
                    if (ok) begin fails = 0; go(M_OPEN); end
                    else begin
                        fails = fails < MAX_FAIL ? fails + 1 : fails;
                        e_err = 1;
                        go(fails == MAX_FAIL ? M_LOCK : M_IDLE);
                    end
                end
                M_OPEN: begin
                    if (set_req) begin newc.delete(); go(M_NEW); end
                    else if (lock_req || clr || spent == OPEN_T) go(M_IDLE);
                end
                M_NEW: begin
                    if (dig) begin
                        newc.push_back(int'(key_value));
                        if (newc.size() == 4) go(M_WRITE); else since = cyc + 1;
                    end else if (clr) go(M_OPEN);
                    else if (spent == IDLE_T) begin e_err = 1; go(M_OPEN); end
                end
                M_WRITE: if (spent == 5) begin
                    for (int i = 0; i < 4; i++) mcode[i] = newc[i];
                    e_done = 1;
                    go(M_IDLE);
                end
                M_LOCK: if (spent == LOCK_T) begin fails = 0; go(M_IDLE); end
                default: ;
            endcase
            cyc++;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            ph = cyc - since;
            chk("m_unlocked", unlocked, mode inside {M_OPEN, M_NEW, M_WRITE});
            chk("m_locked_out", locked_out, mode == M_LOCK);
            chk("m_busy", busy, mode inside {M_CHECK, M_WRITE, M_LOCK});
            chk("m_err_pulse", err_pulse, e_err);
            chk("m_set_done", set_done, e_done);
            chk("m_fail_cnt", fail_cnt, fails);
            chk("m_pwd_set", pwd_set, mode == M_WRITE);
            chk("m_pwd_clr", pwd_clr, mode == M_WRITE && ph == 0);
            chk("m_pwd_wr_en", pwd_wr_en, mode == M_WRITE && ph > 0);
            chk("m_pwd_wr_data", pwd_wr_data, (mode == M_WRITE && ph > 0 && ph <= 4) ? newc[ph-1] : 0);
        end
    end

    task automatic key(input int v);
        key_valid = 1;
        key_value = 4'(v);
        @(negedge clk);
        key_valid = 0;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic setcode(input int a, input int b, input int c, input int d);
        set_req = 1;
        @(negedge clk);
        set_req = 0;
        enter(a, b, c, d);
    endtask

    task automatic zero_chk(input string p);
        chk({p, "_unlocked"}, unlocked, 0);
        chk({p, "_locked_out"}, locked_out, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_err"}, err_pulse, 0);
        chk({p, "_done"}, set_done, 0);
        chk({p, "_fail"}, fail_cnt, 0);
        chk({p, "_clr"}, pwd_clr, 0);
        chk({p, "_set"}, pwd_set, 0);
        chk({p, "_wr_en"}, pwd_wr_en, 0);
        chk({p, "_wr_data"}, pwd_wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0;
        int d9[4];
        d9 = '{9, 8, 7, 6};
        rst = 1; key_valid = 0; key_value = 0; set_req = 0; lock_req = 0;
        repeat (3) @(negedge clk);
        zero_chk("rst");
        rst = 0;
        // initial code 0000 opens, for exactly 500 cycles
        enter(0, 0, 0, 0);
        chk("a_n1_unlocked", unlocked, 0);
        @(negedge clk);
        chk("a_n2_unlocked", unlocked, 1);
        chk("a_fail", fail_cnt, 0);
        n = 1;
        while (unlocked && n < 600) begin
            @(negedge clk);
            if (unlocked) n++;
        end
        chk("a_unlock_len", n, OPEN_T);
        // store 1234, then three wrong entries lock out
        enter(0, 0, 0, 0);
        @(negedge clk);
        setcode(1, 2, 3, 4);
        repeat (5) @(negedge clk);
        chk("b_set_done", set_done, 1);
        chk("b_relocked", unlocked, 0);
        for (int i = 1; i <= 3; i++) begin
            enter(1, 2, 3, 5);
            chk("b_err_early", err_pulse, 0);
            @(negedge clk);
            chk("b_err", err_pulse, 1);
            chk("b_fail_cnt", fail_cnt, i);
            chk("b_locked_out", locked_out, i == 3);
            if (i < 3) @(negedge clk);
        end
        n = 1;
        for (int k = 0; k < 1100 && locked_out; k++) begin
            key_valid = (k % 3) == 0;
            key_value = 4'(k % 16);
            set_req   = (k % 7) == 0;
            lock_req  = (k % 5) == 0;
            @(negedge clk);
            if (locked_out) n++;
        end
        key_valid = 0; set_req = 0; lock_req = 0;
        chk("b_lock_len", n, LOCK_T);
        chk("b_fail_clr", fail_cnt, 0);
        // change 1234 -> 9876 and watch the write sequence
        enter(1, 2, 3, 4);
        @(negedge clk);
        chk("c_unlocked", unlocked, 1);
        setcode(9, 8, 7, 6);
        chk("c_clr", pwd_clr, 1);
        chk("c_set", pwd_set, 1);
        chk("c_wr_en0", pwd_wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("c_wr_en", pwd_wr_en, 1);
            chk("c_wr_data", pwd_wr_data, d9[i]);
            chk("c_clr_off", pwd_clr, 0);
        end
        @(negedge clk);
        chk("c_set_done", set_done, 1);
        chk("c_unlocked_off", unlocked, 0);
        enter(9, 8, 7, 6);
        @(negedge clk);
        chk("c_new_code", unlocked, 1);
        // aborted change leaves storage alone
        w0 = n_writes;
        set_req = 1;
        @(negedge clk);
        set_req = 0;
        key(5); key(5); key(15);
        chk("d_back_open", unlocked, 1);
        chk("d_no_writes", n_writes - w0, 0);
        lock_req = 1;
        @(negedge clk);
        lock_req = 0;
        chk("d_locked", unlocked, 0);
        enter(9, 8, 7, 6);
        @(negedge clk);
        chk("d_old_code", unlocked, 1);
        lock_req = 1;
        @(negedge clk);
        lock_req = 0;
        // inactivity timeout after two digits
        key(1); key(2);
        n = 0;
        while (!err_pulse && n < 2100) begin
            @(negedge clk);
            n++;
        end
        chk("e_timeout_len", n, IDLE_T);
        chk("e_fail_same", fail_cnt, 0);
        @(negedge clk);
        chk("e_err_one", err_pulse, 0);
        enter(9, 8, 7, 6);
        @(negedge clk);
        chk("e_unlock", unlocked, 1);
        // reset in the middle of a storage write
        setcode(1, 1, 1, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        #1 zero_chk("f_rst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("f_idle", unlocked, 0);
        enter(0, 0, 0, 0);
        @(negedge clk);
        chk("f_recovered", unlocked, 1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
